// File: rtl/clint_pkg.sv
// Shared register offsets, request/response types and byte-strobe merge helper
// for the core-local interrupt unit.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } clint_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } clint_rsp_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/core_local_intr_tick_gen.sv
// Prescaler for mtime: counts 0..PRESCALE-1 and pulses tick on the last count.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/core_local_intr.sv
// Machine timer / software interrupt unit with a single-outstanding register port.
// Define CLINT_MSIP_EN to implement the msip register and software interrupt.
module core_local_intr
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [15:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [63:0] o_mtime,
  output logic        o_int_timer,
  output logic        o_int_soft
);

  clint_req_t  req;
  clint_rsp_t  rsp_d;
  clint_rsp_t  rsp_q;
  logic        rsp_valid_q;
  logic        accept;
  logic        wr;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] word_addr;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        unused_addr_bits;

  assign req = '{addr: i_req_addr, write: i_req_write, wdata: i_req_wdata, wstrb: i_req_wstrb};
  assign unused_addr_bits = ^req.addr[1:0];
  assign word_addr = {req.addr[15:2], 2'b00};

  assign o_req_ready = !rsp_valid_q || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;
  assign wr          = accept && req.write;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

`ifdef CLINT_MSIP_EN
  logic msip_q;
  logic sel_msip;
  logic int_soft_q;
`endif

  // Read data reflects register state before this cycle's tick or write.
  always_comb begin
    rsp_d        = '0;
    sel_cmp_lo   = 1'b0;
    sel_cmp_hi   = 1'b0;
    sel_mtime_lo = 1'b0;
    sel_mtime_hi = 1'b0;
`ifdef CLINT_MSIP_EN
    sel_msip     = 1'b0;
`endif
    case (word_addr)
      CLINT_MSIP_OFS: begin
`ifdef CLINT_MSIP_EN
        sel_msip    = 1'b1;
        rsp_d.rdata = {31'd0, msip_q};
`else
        rsp_d.rdata = '0;
`endif
      end
      CLINT_MTIMECMP_LO_OFS: begin
        sel_cmp_lo  = 1'b1;
        rsp_d.rdata = mtimecmp[31:0];
      end
      CLINT_MTIMECMP_HI_OFS: begin
        sel_cmp_hi  = 1'b1;
        rsp_d.rdata = mtimecmp[63:32];
      end
      CLINT_MTIME_LO_OFS: begin
        sel_mtime_lo = 1'b1;
        rsp_d.rdata  = mtime[31:0];
      end
      CLINT_MTIME_HI_OFS: begin
        sel_mtime_hi = 1'b1;
        rsp_d.rdata  = mtime[63:32];
      end
      default: rsp_d.err = 1'b1;
    endcase
    if (req.write) rsp_d.rdata = '0;
  end

  // A write to one half wins over the tick; the other half holds and the tick is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime <= '0;
    end else if (wr && sel_mtime_lo) begin
      mtime[31:0] <= apply_wstrb(mtime[31:0], req.wdata, req.wstrb);
    end else if (wr && sel_mtime_hi) begin
      mtime[63:32] <= apply_wstrb(mtime[63:32], req.wdata, req.wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtimecmp <= '1;
    end else if (wr && sel_cmp_lo) begin
      mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], req.wdata, req.wstrb);
    end else if (wr && sel_cmp_hi) begin
      mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], req.wdata, req.wstrb);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_int_timer <= 1'b0;
    end else begin
      o_int_timer <= (mtime >= mtimecmp);
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      msip_q     <= 1'b0;
      int_soft_q <= 1'b0;
    end else begin
      int_soft_q <= msip_q;
      if (wr && sel_msip && req.wstrb[0]) msip_q <= req.wdata[0];
    end
  end
  assign o_int_soft = int_soft_q;
`else
  assign o_int_soft = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
    end else if (i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_q.rdata;
  assign o_rsp_err   = rsp_q.err;
  assign o_mtime     = mtime;

endmodule
